// File: rtl/hazard_ctrl.sv
// Hazard controller between ID and EX: tracks in-flight destination registers
// and derives stall/flush/freeze controls plus registered EX forward selects.
module hazard_ctrl #(
  parameter int RNW       = 5,
  parameter bit RF_BYPASS = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           id_valid,
  input  logic [RNW-1:0] id_rs1,
  input  logic [RNW-1:0] id_rs2,
  input  logic           id_rs1_used,
  input  logic           id_rs2_used,
  input  logic [RNW-1:0] id_rd,
  input  logic           id_rd_we,
  input  logic           id_is_load,
  input  logic           ex_redirect,
  input  logic           mem_busy,
  output logic           stall_if,
  output logic           stall_id,
  output logic           flush_if,
  output logic           flush_ex,
  output logic           freeze,
  output logic [1:0]     fwd_a_sel,
  output logic [1:0]     fwd_b_sel
);

  typedef struct packed {
    logic           v;
    logic [RNW-1:0] rd;
    logic           we;
    logic           ld;
  } shadow_t;

  shadow_t    exEnt_r, memEnt_r, wbEnt_r, idEnt_s;
  logic [1:0] fwdA_r, fwdB_r, fwdANext_s, fwdBNext_s;
  logic       rs1Ex_s, rs1Mem_s, rs1Wb_s, rs2Ex_s, rs2Mem_s, rs2Wb_s;
  logic       loadUse_s, flushEx_s;

  // x0 is excluded here so it can never forward or interlock.
  function automatic logic srcMatch(input shadow_t p, input logic [RNW-1:0] rs,
                                    input logic used, input logic valid);
    return p.v & p.we & (p.rd == rs) & (rs != {RNW{1'b0}}) & used & valid;
  endfunction

  function automatic logic [1:0] fwdSel(input logic exHit, input logic memHit,
                                        input logic wbHit);
    logic [1:0] sel;
    if (exHit) begin
      sel = 2'd1;
    end else if (memHit) begin
      sel = 2'd2;
    end else if (wbHit && !RF_BYPASS) begin
      sel = 2'd3;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  // Hazard detection, pipeline controls and next forward selects.
  always_comb begin
    rs1Ex_s  = srcMatch(exEnt_r,  id_rs1, id_rs1_used, id_valid);
    rs1Mem_s = srcMatch(memEnt_r, id_rs1, id_rs1_used, id_valid);
    rs1Wb_s  = srcMatch(wbEnt_r,  id_rs1, id_rs1_used, id_valid);
    rs2Ex_s  = srcMatch(exEnt_r,  id_rs2, id_rs2_used, id_valid);
    rs2Mem_s = srcMatch(memEnt_r, id_rs2, id_rs2_used, id_valid);
    rs2Wb_s  = srcMatch(wbEnt_r,  id_rs2, id_rs2_used, id_valid);

    loadUse_s = exEnt_r.ld & (rs1Ex_s | rs2Ex_s);
    flushEx_s = (ex_redirect | loadUse_s) & ~mem_busy;

    freeze   = mem_busy;
    flush_if = ex_redirect & ~mem_busy;
    flush_ex = flushEx_s;
    // A redirect kills the ID instruction, so a pending load-use never stalls it.
    stall_if = loadUse_s & ~ex_redirect & ~mem_busy;
    stall_id = loadUse_s & ~ex_redirect & ~mem_busy;

    // Selects are judged against the stages the producers occupy now; each moves one
    // stage older by the time the consumer reaches EX.
    fwdANext_s = fwdSel(rs1Ex_s, rs1Mem_s, rs1Wb_s);
    fwdBNext_s = fwdSel(rs2Ex_s, rs2Mem_s, rs2Wb_s);

    idEnt_s.v  = id_valid;
    idEnt_s.rd = id_rd;
    idEnt_s.we = id_rd_we;
    idEnt_s.ld = id_is_load;
  end

  // Shadow pipeline advance and forward-select registers; all hold while memory is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exEnt_r  <= '0;
      memEnt_r <= '0;
      wbEnt_r  <= '0;
      fwdA_r   <= 2'd0;
      fwdB_r   <= 2'd0;
    end else if (!mem_busy) begin
      wbEnt_r  <= memEnt_r;
      memEnt_r <= exEnt_r;
      if (flushEx_s) begin
        exEnt_r <= '0;
        fwdA_r  <= 2'd0;
        fwdB_r  <= 2'd0;
      end else begin
        exEnt_r <= idEnt_s;
        fwdA_r  <= fwdANext_s;
        fwdB_r  <= fwdBNext_s;
      end
    end else begin
      wbEnt_r  <= wbEnt_r;
      memEnt_r <= memEnt_r;
      exEnt_r  <= exEnt_r;
      fwdA_r   <= fwdA_r;
      fwdB_r   <= fwdB_r;
    end
  end

  assign fwd_a_sel = fwdA_r;
  assign fwd_b_sel = fwdB_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one write-through and one RF_BYPASS=0 instance
// share stimulus; expected selects are queued at issue and checked after the edge.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rstN;
  logic       idValid, rs1Used, rs2Used, rdWe, isLoad, exRedirect, memBusy;
  logic [4:0] rs1, rs2, rd;

  logic       stallIf, stallId, flushIf, flushEx, freeze;
  logic [1:0] fwdA, fwdB;
  logic       stallIfB, stallIdB, flushIfB, flushExB, freezeB;
  logic [1:0] fwdA0, fwdB0;

  int nTests = 0;
  int nFail  = 0;
  logic [7:0] expQ[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.RNW(5), .RF_BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rstN), .id_valid(idValid), .id_rs1(rs1), .id_rs2(rs2),
    .id_rs1_used(rs1Used), .id_rs2_used(rs2Used), .id_rd(rd), .id_rd_we(rdWe),
    .id_is_load(isLoad), .ex_redirect(exRedirect), .mem_busy(memBusy),
    .stall_if(stallIf), .stall_id(stallId), .flush_if(flushIf), .flush_ex(flushEx),
    .freeze(freeze), .fwd_a_sel(fwdA), .fwd_b_sel(fwdB)
  );

  hazard_ctrl #(.RNW(5), .RF_BYPASS(1'b0)) dutNoBypass (
    .clk(clk), .rst_n(rstN), .id_valid(idValid), .id_rs1(rs1), .id_rs2(rs2),
    .id_rs1_used(rs1Used), .id_rs2_used(rs2Used), .id_rd(rd), .id_rd_we(rdWe),
    .id_is_load(isLoad), .ex_redirect(exRedirect), .mem_busy(memBusy),
    .stall_if(stallIfB), .stall_id(stallIdB), .flush_if(flushIfB), .flush_ex(flushExB),
    .freeze(freezeB), .fwd_a_sel(fwdA0), .fwd_b_sel(fwdB0)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] s1, input logic u1,
                       input logic [4:0] s2, input logic u2, input logic [4:0] d,
                       input logic we, input logic ld, input logic redir, input logic busy);
    idValid = v;  rs1 = s1; rs1Used = u1; rs2 = s2; rs2Used = u2;
    rd = d; rdWe = we; isLoad = ld; exRedirect = redir; memBusy = busy;
  endtask

  // ctl = {stall_if, stall_id, flush_if, flush_ex, freeze}, checked on both builds.
  task automatic checkCtl(input string tag, input logic [4:0] ctl);
    check({tag, ".ctl"},  {3'b000, stallIf, stallId, flushIf, flushEx, freeze}, {3'b000, ctl});
    check({tag, ".ctlB"}, {3'b000, stallIfB, stallIdB, flushIfB, flushExB, freezeB}, {3'b000, ctl});
  endtask

  // One cycle: drive, check controls, queue selects expected after the edge, clock, compare.
  task automatic step(input string tag, input logic v, input logic [4:0] s1, input logic u1,
                      input logic [4:0] s2, input logic u2, input logic [4:0] d,
                      input logic we, input logic ld, input logic redir, input logic busy,
                      input logic [4:0] ctl, input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] a0, input logic [1:0] b0);
    logic [7:0] e;
    drive(v, s1, u1, s2, u2, d, we, ld, redir, busy);
    #1;
    checkCtl(tag, ctl);
    expQ.push_back({a, b, a0, b0});
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      nTests++;
      nFail++;
      $display("FAIL %s.queue observed=empty expected=entry", tag);
    end else begin
      e = expQ.pop_front();
      check({tag, ".fwdA"},  {6'd0, fwdA},  {6'd0, e[7:6]});
      check({tag, ".fwdB"},  {6'd0, fwdB},  {6'd0, e[5:4]});
      check({tag, ".fwdA0"}, {6'd0, fwdA0}, {6'd0, e[3:2]});
      check({tag, ".fwdB0"}, {6'd0, fwdB0}, {6'd0, e[1:0]});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 1'b0;
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkCtl("rst", 5'b00000);
    check("rst.fwdA", {6'd0, fwdA}, 8'd0);
    #2;
    rstN = 1'b1;
    @(posedge clk);
    #1;
    //   tag      v    rs1  u1    rs2  u2    rd   we    ld    redir busy  ctl       a     b     a0    b0
    step("s1",  1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 2'd0, 2'd0, 2'd0, 2'd0);
    step("alu", 1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 2'd0, 2'd0, 2'd0, 2'd0);
    step("ex1", 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 2'd1, 2'd1, 2'd1, 2'd1);
    step("ind", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 2'd0, 2'd0, 2'd0, 2'd0);
    step("mwb", 1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 2'd2, 2'd0, 2'd2, 2'd3);
    step("lw",  1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000, 2'd0, 2'd0, 2'd0, 2'd0);
    step("lu1", 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11010, 2'd0, 2'd0, 2'd0, 2'd0);
    step("lu2", 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 2'd0, 2'd2, 2'd0, 2'd2);
    step("x0p", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000, 2'd0, 2'd0, 2'd0, 2'd0);
    step("x0c", 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000, 2'd0, 2'd0, 2'd0, 2'd0);
    step("rdr", 1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00110, 2'd0, 2'd0, 2'd0, 2'd0);
    step("pre", 1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000, 2'd2, 2'd0, 2'd2, 2'd0);
    for (int i = 0; i < 3; i++) begin
      step("bsy", 1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 5'b00001, 2'd2, 2'd0, 2'd2, 2'd0);
    end
    step("pst", 1'b1, 5'd12, 1'b1, 5'd11, 1'b1, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 5'b11010, 2'd0, 2'd0, 2'd0, 2'd0);
    step("rel", 1'b1, 5'd12, 1'b1, 5'd11, 1'b1, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000, 2'd2, 2'd0, 2'd2, 2'd0);

    // Asynchronous reset with a load-use pending against the load now in EX.
    drive(1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checkCtl("pre_rst", 5'b11010);
    rstN = 1'b0;
    #1;
    checkCtl("mid_rst", 5'b00000);
    check("mid_rst.fwdA", {6'd0, fwdA}, 8'd0);
    check("mid_rst.fwdA0", {6'd0, fwdA0}, 8'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    step("post", 1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 2'd0, 2'd0, 2'd0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller between decode (ID) and execute (EX) of the 5-stage RISC-V core.
- Keeps a shadow pipeline of destination-register records for EX, MEM and WB.
- Produces stall and flush controls, plus registered operand-forward selects that the EX operand muxes use when the issued instruction is in EX.
- Handles load-use interlock, taken-branch redirect and data-memory busy freeze.

Parameters:
- RNW, 5, register-number width.
- RF_BYPASS, 1
  - 1: register file is write-through; a WB match needs no forward.
  - 0: a WB match produces select 3.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  RNW  rs1 number of ID instruction.
- id_rs2  in  RNW  rs2 number of ID instruction.
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2_used  in  1  instruction reads rs2.
- id_rd  in  RNW  destination of ID instruction.
- id_rd_we  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- ex_redirect  in  1  branch/jump taken, resolved in EX.
- mem_busy  in  1  data memory not ready; freeze whole pipeline.
- stall_if  out  1  hold PC and IF/ID.
- stall_id  out  1  hold ID (ID/EX gets a bubble).
- flush_if  out  1  kill IF/ID contents.
- flush_ex  out  1  load a bubble into ID/EX.
- freeze  out  1  hold all pipeline registers (equals mem_busy).
- fwd_a_sel  out  2  EX operand A select, registered.
- fwd_b_sel  out  2  EX operand B select, registered.
- Select encoding: 0 = register file, 1 = EX/MEM result, 2 = MEM/WB result, 3 = WB-stage register.

Behaviour:
- Shadow entry per stage {v, rd, we, ld}. Reset: all cleared, fwd_*_sel = 0.
  - With idle inputs after reset, all control outputs are 0.
- A producer P (x = 1 or 2) matches source rsx when all hold:
  - P.v and P.we
  - P.rd == rsx and rsx != 0
  - id_rsx_used and id_valid
- Register x0 is never forwarded and never stalls.
- load_use: EX entry matches rs1 or rs2 and EX.ld = 1.
- Combinational outputs, evaluated every cycle:
  - freeze = mem_busy.
  - flush_if = ex_redirect & ~mem_busy.
  - flush_ex = (ex_redirect | load_use) & ~mem_busy.
  - stall_if = stall_id = load_use & ~ex_redirect & ~mem_busy.
- Priority: mem_busy > ex_redirect > load_use. A redirect kills the ID instruction, so no stall is raised for it.
- Shadow advance on posedge clk:
  - mem_busy = 1: no register changes; fwd selects hold.
  - Otherwise: WB <= MEM; MEM <= EX.
  - EX <= bubble (v = 0) if flush_ex. Else EX <= {id_valid, id_rd, id_rd_we, id_is_load}.
- Forward select computation, registered only when the ID instruction enters EX (no freeze, no flush_ex). Per operand, youngest producer wins:
  - EX entry matches: 1. The producer is in MEM when the consumer reaches EX.
  - Else MEM entry matches: 2.
  - Else WB entry matches and RF_BYPASS = 0: 3.
  - Else: 0.
- When a bubble enters EX, fwd selects are set to 0.
- Load-use latency: exactly one stall cycle. On the next cycle the load is in MEM and the select is 2.
- Back-to-back loads with dependency chains behave identically per pair.
- rst_n asserted mid-operation: shadow and selects clear immediately (async). No stall or flush persists after release.

Test Plan:
- Reset: hold rst_n = 0 with id_valid = 1, rs1 = 5. Release -> stall/flush = 0 and fwd_a_sel = 0 on the first edge.
- ALU chain: issue add x5 (we); next cycle an instruction with rs1 = 5, rs2 = 5 -> no stall; after edge fwd_a_sel = fwd_b_sel = 1.
  - With one independent instruction in between -> selects = 2.
- Load-use: lw x7, then rs2 = 7 -> stall_if = stall_id = flush_ex = 1 for exactly one cycle; next entry fwd_b_sel = 2, fwd_a_sel = 0.
- x0: a producer writing x0 followed by a consumer with rs1 = 0 -> fwd_a_sel = 0 and no stall, even if ld = 1.
- Redirect vs load-use:
  - Load-use pending and ex_redirect = 1 in the same cycle -> stall = 0, flush_if = flush_ex = 1, EX gets a bubble.
  - Then mem_busy = 1 with redirect -> flush outputs 0, freeze = 1, shadow unchanged across 3 busy cycles.
- RF_BYPASS = 0 build: producer three slots ahead -> select 3. With RF_BYPASS = 1, same stimulus -> select 0.
